puf_resp_reader: RTL and testbench

- Controller and reader for the RO-PUF datapath: the top-level RO arrays, the two 8:1 muxes and the edge counters.
- Takes an N_BITS challenge, which is a list of (sel1, sel2) pairs.
- For each pair it sequences counter clear, mux settle, a timed RO enable window and a post-window hold. It then reads both counts and sets the response bit to the comparison result.
- Delivers the assembled response word with a done pulse. Sits between the host/register interface and the PUF top.

---
 rtl/puf_resp_reader.sv | 220 ++++++++++++++++++++++
 tb/tb_puf_resp_reader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_resp_reader.sv
// Sequencer and reader for the RO-PUF datapath: one (sel1, sel2) challenge pair per
// response bit, each run through clear, settle, timed RO window, hold and sample.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; counters held in clear, sels keep last pair
// CLEAR   | 2 cycles: drive pair i onto the muxes, counters held in clear
// SETTLE  | SETTLE cycles: counters released, mux outputs settling
// MEASURE | WINDOW cycles: ROs and counters enabled
// HOLD    | SETTLE cycles: ROs stopped, counts settling
// SAMPLE  | 1 cycle: compare counts into response[i], update sticky flags
// DONE    | 1 cycle: done pulse, counters back in clear
module puf_resp_reader #(
    parameter int N_BITS = 8,
    parameter int WINDOW = 1000,
    parameter int SETTLE = 4,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [6*N_BITS-1:0] challenge,
    input  logic [CNT_W-1:0]    count_1,
    input  logic [CNT_W-1:0]    count_2,
    output logic [2:0]          sel1,
    output logic [2:0]          sel2,
    output logic                ro_enable,
    output logic                cnt_reset,
    output logic                busy,
    output logic                done,
    output logic [N_BITS-1:0]   response,
    output logic                tie_flag,
    output logic                sat_flag
);

    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int T_MAX = (WINDOW > SETTLE) ? ((WINDOW > 2) ? WINDOW : 2)
                                             : ((SETTLE > 2) ? SETTLE : 2);
    localparam int TMR_W = $clog2(T_MAX + 1);

    localparam logic [TMR_W-1:0] T_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0] T_CLEAR  = TMR_W'(1);
    localparam logic [TMR_W-1:0] T_SETTLE = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] T_WINDOW = TMR_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_MEASURE,
        S_HOLD,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [TMR_W-1:0]    tmr, tmr_nxt;
    logic [IDX_W-1:0]    bit_idx, idx_nxt;
    logic [6*N_BITS-1:0] shadow;
    logic [6*N_BITS-1:0] chal_src;
    logic [5:0]          pairs [N_BITS];
    logic [5:0]          pair_nxt;
    logic                tmr_zero;
    logic                accept;
    logic                load_pair;
    logic                cmp_gt;
    logic                cmp_eq;
    logic                cmp_sat;
    logic                ro_nxt;
    logic                clr_nxt;
    logic                busy_nxt;
    logic                done_nxt;

    assign tmr_zero = (tmr == '0);
    assign accept   = (state == S_IDLE) && start;
    assign cmp_gt   = (count_1 > count_2);
    assign cmp_eq   = (count_1 == count_2);
    assign cmp_sat  = (count_1 == CNT_MAX) || (count_2 == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            tmr     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            tmr     <= tmr_nxt;
            bit_idx <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        idx_nxt   = bit_idx;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CLEAR;
                    tmr_nxt   = T_CLEAR;
                    idx_nxt   = '0;
                end
            end
            S_CLEAR: begin
                if (tmr_zero) begin
                    state_nxt = S_SETTLE;
                    tmr_nxt   = T_SETTLE;
                end else begin
                    tmr_nxt = tmr - T_ONE;
                end
            end
            S_SETTLE: begin
                if (tmr_zero) begin
                    state_nxt = S_MEASURE;
                    tmr_nxt   = T_WINDOW;
                end else begin
                    tmr_nxt = tmr - T_ONE;
                end
            end
            S_MEASURE: begin
                if (tmr_zero) begin
                    state_nxt = S_HOLD;
                    tmr_nxt   = T_SETTLE;
                end else begin
                    tmr_nxt = tmr - T_ONE;
                end
            end
            S_HOLD: begin
                if (tmr_zero) begin
                    state_nxt = S_SAMPLE;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr - T_ONE;
                end
            end
            S_SAMPLE: begin
                if (bit_idx == IDX_LAST) begin
                    state_nxt = S_DONE;
                    tmr_nxt   = '0;
                end else begin
                    state_nxt = S_CLEAR;
                    tmr_nxt   = T_CLEAR;
                    idx_nxt   = bit_idx + IDX_ONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                tmr_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                tmr_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        ro_nxt   = (state_nxt == S_MEASURE);
        clr_nxt  = (state_nxt == S_IDLE) || (state_nxt == S_CLEAR) || (state_nxt == S_DONE);
        busy_nxt = (state_nxt == S_CLEAR) || (state_nxt == S_SETTLE) ||
                   (state_nxt == S_MEASURE) || (state_nxt == S_HOLD) ||
                   (state_nxt == S_SAMPLE);
        done_nxt = (state_nxt == S_DONE);
        load_pair = (state_nxt == S_CLEAR) && (state != S_CLEAR);
    end

    // On the accepting edge the shadow is not loaded yet, so pair 0 comes straight from the port.
    always_comb begin
        chal_src = (state == S_IDLE) ? challenge : shadow;
        for (int i = 0; i < N_BITS; i++) begin
            pairs[i] = chal_src[6*i +: 6];
        end
    end

    assign pair_nxt = pairs[idx_nxt];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel1      <= 3'd0;
            sel2      <= 3'd0;
            ro_enable <= 1'b0;
            cnt_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            response  <= '0;
            tie_flag  <= 1'b0;
            sat_flag  <= 1'b0;
            shadow    <= '0;
        end else begin
            ro_enable <= ro_nxt;
            cnt_reset <= clr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            if (load_pair) begin
                sel1 <= pair_nxt[2:0];
                sel2 <= pair_nxt[5:3];
            end
            if (accept) begin
                shadow   <= challenge;
                response <= '0;
                tie_flag <= 1'b0;
                sat_flag <= 1'b0;
            end else if (state == S_SAMPLE) begin
                response[bit_idx] <= cmp_gt;
                if (cmp_eq) begin
                    tie_flag <= 1'b1;
                end
                if (cmp_sat) begin
                    sat_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_resp_reader.sv
// Bench for puf_resp_reader: a frequency-table RO/counter model drives the counts and a
// table-lookup reference predicts response, flags and done latency.
module tb_puf_resp_reader;

    localparam int NB       = 4;
    localparam int WIN      = 16;
    localparam int ST       = 2;
    localparam int CW       = 8;
    localparam int P        = 2 + ST + WIN + ST + 1;
    localparam int DONE_LAT = 1 + NB * P;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [6*NB-1:0] challenge;
    logic [CW-1:0]   count_1;
    logic [CW-1:0]   count_2;
    logic [2:0]      sel1;
    logic [2:0]      sel2;
    logic            ro_enable;
    logic            cnt_reset;
    logic            busy;
    logic            done;
    logic [NB-1:0]   response;
    logic            tie_flag;
    logic            sat_flag;

    int total = 0;
    int bad   = 0;

    int tbl1 [8];
    int tbl2 [8];
    int en_cyc = 0;

    logic [6*NB-1:0] exp_chal = '0;
    int   done_cnt = 0;
    int   ro_run   = 0;
    int   cr_run   = 0;
    int   mon_bit  = 0;
    int   sel_bad  = 0;
    logic prev_clr = 1'b0;
    logic [5:0] sel_hold = '0;

    puf_resp_reader #(
        .N_BITS(NB),
        .WINDOW(WIN),
        .SETTLE(ST),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .challenge(challenge),
        .count_1  (count_1),
        .count_2  (count_2),
        .sel1     (sel1),
        .sel2     (sel2),
        .ro_enable(ro_enable),
        .cnt_reset(cnt_reset),
        .busy     (busy),
        .done     (done),
        .response (response),
        .tie_flag (tie_flag),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] scale(input int v, input int e);
        return CW'((v * e) / WIN);
    endfunction

    function automatic logic [5:0] pair(input int s1, input int s2);
        return {3'(s2), 3'(s1)};
    endfunction

    // Reference: each bit is the comparison of the two looked-up oscillator counts.
    task automatic ref_model(input logic [6*NB-1:0] chal, output logic [NB-1:0] r,
                             output logic t, output logic s);
        int c1, c2;
        r = '0;
        t = 1'b0;
        s = 1'b0;
        for (int i = 0; i < NB; i++) begin
            c1 = tbl1[chal[6*i +: 3]];
            c2 = tbl2[chal[6*i+3 +: 3]];
            r[i] = (c1 > c2);
            if (c1 == c2) t = 1'b1;
            if (c1 == 255 || c2 == 255) s = 1'b1;
        end
    endtask

    task automatic clear_tbls();
        for (int i = 0; i < 8; i++) begin
            tbl1[i] = 0;
            tbl2[i] = 0;
        end
    endtask

    task automatic basic_tbls();
        clear_tbls();
        tbl1[1] = 40; tbl2[2] = 30;
        tbl1[3] = 10; tbl2[4] = 20;
        tbl1[5] = 50; tbl2[6] = 49;
        tbl1[7] = 7;  tbl2[0] = 9;
    endtask

    // RO + edge counter model: counts ramp while enabled and reach the table value after WIN cycles.
    always @(negedge clk) begin
        if (reset || cnt_reset) en_cyc = 0;
        else if (ro_enable && en_cyc < WIN) en_cyc++;
        count_1 = scale(tbl1[sel1], en_cyc);
        count_2 = scale(tbl2[sel2], en_cyc);
    end

    always @(negedge clk) begin
        if (reset) begin
            ro_run   = 0;
            cr_run   = 0;
            mon_bit  = 0;
            prev_clr = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (ro_enable) begin
                ro_run++;
            end else if (ro_run != 0) begin
                chk("ro_run", ro_run, WIN);
                ro_run = 0;
            end
            if (busy && cnt_reset) begin
                cr_run++;
                if (!prev_clr) begin
                    chk("sel_pair", {26'd0, sel2, sel1}, {26'd0, exp_chal[6*mon_bit +: 6]});
                    mon_bit++;
                end
                sel_hold = {sel2, sel1};
            end else begin
                if (cr_run != 0) begin
                    chk("clr_run", cr_run, 2);
                    cr_run = 0;
                end
                if (busy && ({sel2, sel1} != sel_hold)) sel_bad++;
            end
            if (!busy) mon_bit = 0;
            prev_clr = busy && cnt_reset;
        end
    end

    // Called at a negedge while the DUT is idle; start is presented in that same cycle.
    task automatic run_word(input logic [6*NB-1:0] chal, input bit disturb, input string tag);
        logic [NB-1:0] er;
        logic et, es;
        int n, dc0;
        ref_model(chal, er, et, es);
        exp_chal  = chal;
        dc0       = done_cnt;
        challenge = chal;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        if (disturb) challenge = ~chal;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_clr"}, {response, tie_flag, sat_flag}, 0);
        while (!done && n < DONE_LAT + 50) begin
            @(negedge clk);
            n++;
            if (disturb) begin
                if (n == 30 || n == 70) begin
                    start     = 1'b1;
                    challenge = (6*NB)'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
        end
        chk({tag, "_lat"}, n, DONE_LAT);
        chk({tag, "_resp"}, response, er);
        chk({tag, "_tie"}, tie_flag, et);
        chk({tag, "_sat"}, sat_flag, es);
        chk({tag, "_busy_done"}, busy, 0);
        if (disturb) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_pulse"}, {done, busy}, 0);
        chk({tag, "_hold"}, {response, tie_flag, sat_flag}, {er, et, es});
        chk({tag, "_last_sel"}, {sel2, sel1}, chal[6*(NB-1) +: 6]);
        #1;
        chk({tag, "_ndone"}, done_cnt - dc0, 1);
        chk({tag, "_sel_stable"}, sel_bad, 0);
        sel_bad = 0;
    endtask

    task automatic rand_tbls();
        int r;
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 9);
            tbl1[i] = (r == 0) ? 255 : $urandom_range(0, 12);
            r = $urandom_range(0, 9);
            tbl2[i] = (r == 0) ? 255 : $urandom_range(0, 12);
        end
    endtask

    initial begin
        logic [6*NB-1:0] basic_chal;
        logic [NB-1:0]   er;
        logic            et, es;
        int              dc0;

        reset     = 1'b1;
        start     = 1'b0;
        challenge = '0;
        count_1   = '0;
        count_2   = '0;
        clear_tbls();
        repeat (3) @(negedge clk);
        chk("rst_state",
            {sel1, sel2, ro_enable, cnt_reset, busy, done, response, tie_flag, sat_flag},
            {6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
        reset = 1'b0;
        @(negedge clk);

        basic_chal = {pair(7, 0), pair(5, 6), pair(3, 4), pair(1, 2)};
        basic_tbls();
        run_word(basic_chal, 1'b0, "basic");
        chk("basic_word", response, 4'b0101);

        clear_tbls();
        tbl1[0] = 25;  tbl2[0] = 25;
        tbl1[1] = 255; tbl2[2] = 100;
        tbl1[3] = 5;   tbl2[4] = 1;
        tbl1[5] = 0;   tbl2[6] = 3;
        run_word({pair(5, 6), pair(3, 4), pair(1, 2), pair(0, 0)}, 1'b0, "tiesat");
        chk("tiesat_word", {response, tie_flag, sat_flag}, {4'b0110, 1'b1, 1'b1});

        basic_tbls();
        run_word(basic_chal, 1'b0, "b2b");

        rand_tbls();
        run_word((6*NB)'($urandom), 1'b1, "disturb");

        // Async reset in the middle of bit 2's measurement window.
        basic_tbls();
        ref_model(basic_chal, er, et, es);
        exp_chal  = basic_chal;
        challenge = basic_chal;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (54) @(negedge clk);
        chk("rst_pre_ro", ro_enable, 1);
        chk("rst_pre_part", response[1:0], er[1:0]);
        dc0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        chk("rst_async", {ro_enable, busy, done, cnt_reset, response}, {1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (120) @(negedge clk);
        #1;
        chk("rst_no_done", done_cnt - dc0, 0);
        chk("rst_idle", {busy, response}, 0);
        sel_bad = 0;

        run_word(basic_chal, 1'b0, "post_rst");

        for (int k = 0; k < 6; k++) begin
            rand_tbls();
            run_word((6*NB)'($urandom), 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
